branching_logic: RTL and testbench
==================================

# branching_logic

Next-PC selection block of the single-cycle CPU. It evaluates a 4-bit branch condition code against the ALU status flags (zero, sign, carry, overflow) and, when a branch instruction is active and the condition holds, selects the jump target. Otherwise it selects the sequential PC. The selected next PC is registered and fed back to the instruction-fetch stage.

## Interface
Parameters:
- ADDR_W, 32: width of all PC/address buses.
- PC_STEP, 4: byte increment for the sequential (not-taken) PC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- jump_addr  input  ADDR_W  absolute branch/jump target.
- zero_flag  input  1  ALU result == 0.
- sign_flag  input  1  ALU result MSB.
- carry_flag  input  1  ALU carry-out (1 = no borrow on subtract).
- overflow_flag  input  1  ALU signed overflow.
- FlagControl  input  4  condition code, encoding below.
- BranchControl  input  1  1 = current instruction is a branch/jump.
- program_counter_in  input  ADDR_W  PC of the current instruction.
- program_counter_out  output  ADDR_W  registered next PC.
- branch_taken  output  1  registered: 1 when the last update took the jump.

## Operation
- Let lt = sign_flag XOR overflow_flag.
- The condition code `cond` is decoded from FlagControl as follows:
  - 0000 always.
  - 0001 Z.
  - 0010 !Z.
  - 0011 S.
  - 0100 !S.
  - 0101 C.
  - 0110 !C.
  - 0111 V.
  - 1000 !V.
  - 1001 lt (signed <).
  - 1010 !lt (signed >=).
  - 1011 !Z & !lt (signed >).
  - 1100 Z | lt (signed <=).
  - 1101 C & !Z (unsigned >).
  - 1110 !C | Z (unsigned <=).
  - 1111 never.
- take = BranchControl & cond.
- Next value is computed as follows:
  - If take, the next value is jump_addr.
  - Otherwise it is program_counter_in + PC_STEP, modulo 2^ADDR_W; wrap-around is silent.
- When BranchControl = 0, FlagControl and the flags are ignored.
- jump_addr is used verbatim, with no alignment check and no masking.

## Timing
- Condition decode and next-PC mux are purely combinational from the inputs.
- program_counter_out and branch_taken update on every rising clk edge, so latency is 1 cycle from inputs to outputs.
- Reset, when rst_n = 0 at a rising edge:
  - program_counter_out <= 0.
  - branch_taken <= 0.
  - Reset has priority over all inputs.
- Reset asserted mid-operation discards the pending next PC.
- The first post-reset edge with rst_n = 1 loads the normally computed value.
- No enable and no handshake: the register loads every cycle.
- There is no internal state beyond the two output registers.

## Structure
- Shared package holds:
  - ADDR_W default.
  - PC_STEP default.
  - The 16 condition-code constants (COND_AL, COND_EQ, COND_NE, COND_MI, COND_PL, COND_CS, COND_CC, COND_VS, COND_VC, COND_LT, COND_GE, COND_GT, COND_LE, COND_HI, COND_LS, COND_NV), which are shared with the control unit's decoder.
- One sub-module: branch_cond_eval.
  - Combinational; inputs are the four flags and the 4-bit code; output is 1-bit cond.
  - The top level adds the BranchControl gate, the adder, the mux and the output registers.

## Test plan
- Reset:
  - Hold rst_n = 0 for 2 edges with arbitrary inputs → program_counter_out = 0, branch_taken = 0.
  - Release rst_n with BranchControl = 0, program_counter_in = 0 → next edge program_counter_out = 4, branch_taken = 0.
- Signed-LE not taken: jump_addr = 40, Z = 0, S = 1, C = 0, V = 1, FlagControl = 1100, BranchControl = 1, program_counter_in = 0 → lt = 0, cond false, so program_counter_out = 4 and branch_taken = 0 after one edge.
- Signed-LE taken: same inputs but V = 0 → program_counter_out = 40, branch_taken = 1. Separately, Z = 1 with S = V = 1 also gives 40.
- Condition-code sweep with BranchControl = 1, jump_addr = 0x100, program_counter_in = 0x20:
  - Iterate all 16 codes × all 16 flag combinations.
  - Required response: 0x100 exactly when the decode rule holds, else 0x24.
  - Code 0000 → always 0x100; code 1111 → always 0x24.
- Gating and wrap:
  - BranchControl = 0, FlagControl = 0000, program_counter_in = 0xFFFFFFFC → program_counter_out = 0x00000000, branch_taken = 0.
- Reset mid-stream:
  - Assert rst_n = 0 in the same cycle as a taken branch to 40 → output 0, not 40.
  - Next edge with rst_n = 1 → 40.

Source files
------------

// File: rtl/branching_logic_pkg.sv
// Shared constants for next-PC selection: bus defaults and branch condition codes.
// The condition-code constants are also used by the control unit's decoder.
package branching_logic_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int PC_STEP_DEF = 4;

    localparam logic [3:0] COND_AL = 4'b0000;
    localparam logic [3:0] COND_EQ = 4'b0001;
    localparam logic [3:0] COND_NE = 4'b0010;
    localparam logic [3:0] COND_MI = 4'b0011;
    localparam logic [3:0] COND_PL = 4'b0100;
    localparam logic [3:0] COND_CS = 4'b0101;
    localparam logic [3:0] COND_CC = 4'b0110;
    localparam logic [3:0] COND_VS = 4'b0111;
    localparam logic [3:0] COND_VC = 4'b1000;
    localparam logic [3:0] COND_LT = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_GT = 4'b1011;
    localparam logic [3:0] COND_LE = 4'b1100;
    localparam logic [3:0] COND_HI = 4'b1101;
    localparam logic [3:0] COND_LS = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/branching_logic_cond_eval.sv
// Combinational branch condition evaluator.
// Ports: zero/sign/carry/overflow flags, 4-bit code in; 1-bit cond out.
module branch_cond_eval
    import branching_logic_pkg::*;
(
    input  logic       zero_flag,
    input  logic       sign_flag,
    input  logic       carry_flag,
    input  logic       overflow_flag,
    input  logic [3:0] code,
    output logic       cond
);

    logic lt;

    // signed less-than after a subtract
    assign lt = sign_flag ^ overflow_flag;

    always_comb begin
        cond = 1'b0;
        unique case (code)
            COND_AL: cond = 1'b1;
            COND_EQ: cond = zero_flag;
            COND_NE: cond = !zero_flag;
            COND_MI: cond = sign_flag;
            COND_PL: cond = !sign_flag;
            COND_CS: cond = carry_flag;
            COND_CC: cond = !carry_flag;
            COND_VS: cond = overflow_flag;
            COND_VC: cond = !overflow_flag;
            COND_LT: cond = lt;
            COND_GE: cond = !lt;
            COND_GT: cond = !zero_flag && !lt;
            COND_LE: cond = zero_flag || lt;
            COND_HI: cond = carry_flag && !zero_flag;
            COND_LS: cond = !carry_flag || zero_flag;
            COND_NV: cond = 1'b0;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branching_logic.sv
// Next-PC selection: picks jump_addr on a taken branch, else PC + PC_STEP.
// Ports: clk, rst_n (sync, low), flags, FlagControl, BranchControl, PCs in/out, branch_taken.
module branching_logic
    import branching_logic_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              zero_flag,
    input  logic              sign_flag,
    input  logic              carry_flag,
    input  logic              overflow_flag,
    input  logic [3:0]        FlagControl,
    input  logic              BranchControl,
    input  logic [ADDR_W-1:0] program_counter_in,
    output logic [ADDR_W-1:0] program_counter_out,
    output logic              branch_taken
);

    logic              cond;
    logic              take;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] next_pc;

    branch_cond_eval u_cond (
        .zero_flag    (zero_flag),
        .sign_flag    (sign_flag),
        .carry_flag   (carry_flag),
        .overflow_flag(overflow_flag),
        .code         (FlagControl),
        .cond         (cond)
    );

    assign take    = BranchControl & cond;
    // wraps silently at 2^ADDR_W
    assign seq_pc  = program_counter_in + ADDR_W'(PC_STEP);
    assign next_pc = take ? jump_addr : seq_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            program_counter_out <= '0;
            branch_taken        <= 1'b0;
        end else begin
            program_counter_out <= next_pc;
            branch_taken        <= take;
        end
    end

endmodule

// File: tb/tb_branching_logic.sv
// Directed + randomized bench for branching_logic against a behavioural model.
// Prints one summary line with compared/mismatched counts.
module tb_branching_logic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] jump_addr;
    logic        zero_flag;
    logic        sign_flag;
    logic        carry_flag;
    logic        overflow_flag;
    logic [3:0]  FlagControl;
    logic        BranchControl;
    logic [31:0] program_counter_in;
    logic [31:0] program_counter_out;
    logic        branch_taken;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_pc;
    logic        exp_bt;

    branching_logic dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .jump_addr          (jump_addr),
        .zero_flag          (zero_flag),
        .sign_flag          (sign_flag),
        .carry_flag         (carry_flag),
        .overflow_flag      (overflow_flag),
        .FlagControl        (FlagControl),
        .BranchControl      (BranchControl),
        .program_counter_in (program_counter_in),
        .program_counter_out(program_counter_out),
        .branch_taken       (branch_taken)
    );

    always #5 clk = ~clk;

    // Reference: condition as the relation it expresses
    function automatic bit ref_cond(int code, bit z, bit s, bit c, bit v);
        bit lt;
        lt = (s != v);
        case (code)
            0:  return 1;
            1:  return z;
            2:  return !z;
            3:  return s;
            4:  return !s;
            5:  return c;
            6:  return !c;
            7:  return v;
            8:  return !v;
            9:  return lt;
            10: return !lt;
            11: return !(z || lt);
            12: return z || lt;
            13: return c && !z;
            14: return !(c && !z);
            default: return 0;
        endcase
    endfunction

    task automatic model();
        bit t;
        t = BranchControl && ref_cond(int'(FlagControl), zero_flag,
                                      sign_flag, carry_flag, overflow_flag);
        if (!rst_n) begin
            exp_pc = 32'd0;
            exp_bt = 1'b0;
        end else begin
            exp_pc = t ? jump_addr : 32'((64'(program_counter_in) + 64'd4) % 64'h1_0000_0000);
            exp_bt = t;
        end
    endtask

    task automatic check(string tag);
        compared++;
        assert (program_counter_out === exp_pc && branch_taken === exp_bt)
        else begin
            mismatched++;
            $error("FAIL %s: pc=%h bt=%b, required pc=%h bt=%b",
                   tag, program_counter_out, branch_taken, exp_pc, exp_bt);
        end
    endtask

    // model the pending inputs, clock once, sample 1 time unit later
    task automatic step(string tag);
        model();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic set_flags(bit z, bit s, bit c, bit v);
        zero_flag     = z;
        sign_flag     = s;
        carry_flag    = c;
        overflow_flag = v;
    endtask

    task automatic randomize_inputs();
        jump_addr          = $urandom;
        program_counter_in = $urandom;
        set_flags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        FlagControl   = 4'($urandom);
        BranchControl = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        randomize_inputs();
        step("reset_1");
        randomize_inputs();
        step("reset_2");

        rst_n              = 1'b1;
        BranchControl      = 1'b0;
        program_counter_in = 32'd0;
        step("release");

        jump_addr          = 32'd40;
        FlagControl        = 4'b1100;
        BranchControl      = 1'b1;
        program_counter_in = 32'd0;
        set_flags(1'b0, 1'b1, 1'b0, 1'b1);
        step("le_not_taken");
        if (program_counter_out !== 32'd4) begin
            mismatched++;
            $error("FAIL le_not_taken_const: pc=%h required 4", program_counter_out);
        end
        compared++;

        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step("le_taken_lt");
        set_flags(1'b1, 1'b1, 1'b0, 1'b1);
        step("le_taken_z");
        if (program_counter_out !== 32'd40) begin
            mismatched++;
            $error("FAIL le_taken_const: pc=%h required 40", program_counter_out);
        end
        compared++;

        jump_addr          = 32'h100;
        program_counter_in = 32'h20;
        BranchControl      = 1'b1;
        for (int code = 0; code < 16; code++) begin
            for (int f = 0; f < 16; f++) begin
                FlagControl = 4'(code);
                set_flags(f[3], f[2], f[1], f[0]);
                step($sformatf("sweep_c%0d_f%0d", code, f));
                if (code == 0 || code == 15) begin
                    compared++;
                    if (program_counter_out !== (code == 0 ? 32'h100 : 32'h24)) begin
                        mismatched++;
                        $error("FAIL sweep_fixed_c%0d: pc=%h required %h", code,
                               program_counter_out, code == 0 ? 32'h100 : 32'h24);
                    end
                end
            end
        end

        BranchControl      = 1'b0;
        FlagControl        = 4'b0000;
        program_counter_in = 32'hFFFF_FFFC;
        step("wrap");

        jump_addr          = 32'd40;
        BranchControl      = 1'b1;
        FlagControl        = 4'b0000;
        program_counter_in = 32'h1000;
        rst_n              = 1'b0;
        step("mid_reset");
        rst_n = 1'b1;
        step("post_reset_taken");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            rst_n = ($urandom_range(0, 19) != 0);
            if (i % 7 == 0) BranchControl = 1'b0;
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
